serial_compare_sequencer: RTL

SERIAL_COMPARE_SEQUENCER -- requirements
Module: serial_compare_sequencer

---
 rtl/serial_compare_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serial_compare_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : serial_compare_sequencer
// Description : Accepts an operand pair, clears a downstream MSB-first serial
//               comparator, streams both operands to it one bit per cycle and
//               captures the comparator's result flags after the last bit.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_compare_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  output logic             up_ready,
  output logic             cmp_clear,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  input  logic             cmp_less,
  input  logic             cmp_eq,
  input  logic             cmp_greater,
  output logic             res_valid,
  output logic             res_less,
  output logic             res_eq,
  output logic             res_greater,
  output logic             res_error
);

  localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_sh_a;
  logic [WIDTH-1:0]     r_sh_b;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_onehot;

  // Exactly one of three flags set: odd parity rules out two set, and the
  // AND term rules out all three set.
  assign w_onehot = (cmp_less ^ cmp_eq ^ cmp_greater) & ~(cmp_less & cmp_eq & cmp_greater);

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and all state-derived outputs.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    up_ready  = 1'b0;
    cmp_clear = 1'b0;
    ser_valid = 1'b0;
    ser_a     = 1'b0;
    ser_b     = 1'b0;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Ready is withheld while reset is held, even though the state is IDLE.
        up_ready = rst;
        w_accept = up_valid;
        if (up_valid) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cmp_clear = 1'b1;
        w_next    = S_SHIFT;
      end
      S_SHIFT: begin
        ser_valid = 1'b1;
        ser_a     = r_sh_a[WIDTH-1];
        ser_b     = r_sh_b[WIDTH-1];
        ser_first = (r_cnt == '0);
        ser_last  = (r_cnt == c_cnt_last);
        w_last    = ser_last;
        if (ser_last) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand shift registers and bit counter; MSB is always presented first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_a <= '0;
      r_sh_b <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_sh_a <= up_a;
      r_sh_b <= up_b;
      r_cnt  <= '0;
    end else if (ser_valid) begin
      r_sh_a <= r_sh_a << 1;
      r_sh_b <= r_sh_b << 1;
      r_cnt  <= w_last ? '0 : r_cnt + c_cnt_w'(1);
    end
  end

  // Result capture at the end of the last bit; flags hold until next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid   <= 1'b0;
      res_less    <= 1'b0;
      res_eq      <= 1'b0;
      res_greater <= 1'b0;
      res_error   <= 1'b0;
    end else begin
      res_valid <= w_last;
      if (w_last) begin
        res_less    <= cmp_less;
        res_eq      <= cmp_eq;
        res_greater <= cmp_greater;
        res_error   <= ~w_onehot;
      end
    end
  end

endmodule
`default_nettype wire
